// File: rtl/cmd_issuer.sv
// cmd_issuer: queues host command words and replays each onto cmd_data with a
// setup / strobe / gap window so the controller sees one clean latch_data edge per word.
`timescale 1ns/1ps
module cmd_issuer #(
    parameter int DEPTH         = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] host_wdata,
    input  logic        host_wr_en,
    input  logic        flush,
    output logic        host_full,
    output logic [31:0] cmd_data,
    output logic        latch_data,
    output logic        busy,
    output logic [15:0] issued_count,
    output logic        overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] GAP_LD    = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    state_t        state, state_nx;
    logic [7:0]    phase, phase_nx;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, done, queued;

    assign host_full = count == (AW+1)'(DEPTH);
    assign busy      = state != IDLE || queued;
    assign queued    = count != '0;
    assign done      = phase == 8'd0;
    assign push      = host_wr_en && !host_full && !flush;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE:    if (queued && !flush) begin
                         state_nx = SETUP;
                         pop      = 1'b1;
                     end
            SETUP:   state_nx = flush ? IDLE : (done ? STROBE : SETUP);
            STROBE:  state_nx = done ? GAP : STROBE;
            GAP:     if (done) begin
                         pop      = queued && !flush;
                         state_nx = pop ? SETUP : IDLE;
                     end
            default: state_nx = IDLE;
        endcase
        // every state entry reloads the phase counter with that state's length minus one
        phase_nx = (state_nx == state) ? (done ? phase : phase - 8'd1) :
                   (state_nx == SETUP)  ? SETUP_LD  :
                   (state_nx == STROBE) ? STROBE_LD :
                   (state_nx == GAP)    ? GAP_LD    : 8'd0;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= host_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= 8'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cmd_data     <= 32'd0;
            latch_data   <= 1'b0;
            issued_count <= 16'd0;
            overflow     <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            latch_data <= state_nx == STROBE;
            if (state == SETUP && state_nx == STROBE)
                issued_count <= issued_count + 16'd1;
            if (pop)
                cmd_data <= mem[rd_ptr];
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                wr_ptr   <= wr_ptr + AW'(push);
                rd_ptr   <= rd_ptr + AW'(pop);
                count    <= count + (AW+1)'(push) - (AW+1)'(pop);
                overflow <= overflow || (host_wr_en && host_full);
            end
        end
    end
endmodule

// File: tb/tb_cmd_issuer.sv
// tb_cmd_issuer: scoreboard bench for cmd_issuer; three instances cover the default,
// long-setup (overflow) and medium-setup (flush in setup) configurations.
`timescale 1ns/1ps
module tb_cmd_issuer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wdata = 32'd0;
    logic        flush = 1'b0;
    logic        wr_a = 1'b0, wr_b = 1'b0, wr_c = 1'b0;
    logic        full_a, full_b, full_c, latch_a, latch_b, latch_c;
    logic        busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
    logic [31:0] cmd_a, cmd_b, cmd_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    int          nvec = 0, nfail = 0, cyc = 0;
    logic [31:0] qa[$], qb[$], qc[$];
    int          rise_a[$];
    logic        pl_a = 1'b0, pl_b = 1'b0, pl_c = 1'b0;
    int          hi_a = 0, hi_b = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    cmd_issuer dut_a (.clock(clock), .reset(reset), .host_wdata(wdata), .host_wr_en(wr_a),
        .flush(flush), .host_full(full_a), .cmd_data(cmd_a), .latch_data(latch_a),
        .busy(busy_a), .issued_count(cnt_a), .overflow(ovf_a));
    cmd_issuer #(.SETUP_CYCLES(10)) dut_b (.clock(clock), .reset(reset), .host_wdata(wdata),
        .host_wr_en(wr_b), .flush(flush), .host_full(full_b), .cmd_data(cmd_b),
        .latch_data(latch_b), .busy(busy_b), .issued_count(cnt_b), .overflow(ovf_b));
    cmd_issuer #(.SETUP_CYCLES(4)) dut_c (.clock(clock), .reset(reset), .host_wdata(wdata),
        .host_wr_en(wr_c), .flush(flush), .host_full(full_c), .cmd_data(cmd_c),
        .latch_data(latch_c), .busy(busy_c), .issued_count(cnt_c), .overflow(ovf_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // each rising strobe consumes the oldest expected word; width is checked on the fall
    always @(negedge clock) begin
        if (reset) begin
            pl_a = 1'b0; pl_b = 1'b0; pl_c = 1'b0; hi_a = 0; hi_b = 0;
        end else begin
            if (latch_a && !pl_a) begin
                rise_a.push_back(cyc);
                if (qa.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL a_strobe: unexpected strobe with cmd_data %h, none expected", cmd_a);
                end else chk("a_strobe_data", cmd_a, qa.pop_front());
            end
            if (latch_b && !pl_b) begin
                if (qb.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL b_strobe: unexpected strobe with cmd_data %h, none expected", cmd_b);
                end else chk("b_strobe_data", cmd_b, qb.pop_front());
            end
            if (latch_c && !pl_c) begin
                if (qc.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL c_strobe: unexpected strobe with cmd_data %h, none expected", cmd_c);
                end else chk("c_strobe_data", cmd_c, qc.pop_front());
            end
            if (latch_a) hi_a++;
            else if (pl_a) begin chk("a_strobe_width", hi_a, 2); hi_a = 0; end
            if (latch_b) hi_b++;
            else if (pl_b) begin chk("b_strobe_width", hi_b, 2); hi_b = 0; end
            pl_a = latch_a; pl_b = latch_b; pl_c = latch_c;
        end
    end

    initial begin
        int base;
        #1;
        chk("rst_cmd", cmd_a, 32'd0);
        chk("rst_latch", latch_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_b_busy", busy_b, 0);
        chk("rst_c_cmd", cmd_c, 32'd0);
        #11 reset = 1'b0;
        tick(2);

        // single word: latency and strobe placement
        wdata = 32'hC800_0000; wr_a = 1'b1; qa.push_back(wdata);
        tick(1); wr_a = 1'b0;
        chk("t1_cmd_t", cmd_a, 32'd0);
        chk("t1_busy_t", busy_a, 1);
        tick(1);
        chk("t1_cmd_t1", cmd_a, 32'hC800_0000);
        chk("t1_latch_t1", latch_a, 0);
        tick(1);
        chk("t1_latch_t2", latch_a, 1);
        chk("t1_count", cnt_a, 1);
        tick(1);
        chk("t1_latch_t3", latch_a, 1);
        tick(1);
        chk("t1_latch_t4", latch_a, 0);
        chk("t1_busy_gap", busy_a, 1);
        tick(1);
        chk("t1_busy_t5", busy_a, 1);
        tick(1);
        chk("t1_busy_idle", busy_a, 0);
        chk("t1_cmd_hold", cmd_a, 32'hC800_0000);

        // burst of 1..4 behind an in-flight word fills the FIFO
        base = rise_a.size();
        for (int i = 0; i < 5; i++) begin
            wdata = (i == 0) ? 32'h5A5A_5A5A : 32'(i);
            wr_a = 1'b1; qa.push_back(wdata);
            tick(1);
        end
        wr_a = 1'b0;
        chk("burst_full", full_a, 1);
        chk("burst_ovf", ovf_a, 0);
        tick(1);
        chk("burst_full_hold", full_a, 1);
        tick(1);
        chk("burst_full_drop", full_a, 0);
        tick(25);
        chk("burst_strobes", rise_a.size(), base + 5);
        for (int i = 1; i < 5; i++)
            chk("burst_spacing", rise_a[base+i] - rise_a[base+i-1], 5);
        chk("burst_count", cnt_a, 6);
        chk("burst_ovf_end", ovf_a, 0);

        // flush during strobe: strobe and gap complete, second word is dropped
        wdata = 32'hAAAA_0001; wr_a = 1'b1; qa.push_back(wdata);
        tick(1);
        wdata = 32'hAAAA_0002;
        tick(1); wr_a = 1'b0;
        tick(1);
        chk("fs_latch_rise", latch_a, 1);
        flush = 1'b1;
        tick(1); flush = 1'b0;
        chk("fs_latch_hold", latch_a, 1);
        tick(1);
        chk("fs_latch_fall", latch_a, 0);
        tick(1);
        chk("fs_busy_gap", busy_a, 1);
        tick(1);
        chk("fs_busy_idle", busy_a, 0);
        tick(6);
        chk("fs_count", cnt_a, 7);

        // async reset in the second strobe cycle
        wdata = 32'h1234_5678; wr_a = 1'b1; qa.push_back(wdata);
        tick(1); wr_a = 1'b0;
        tick(3);
        #1 reset = 1'b1;
        #1;
        chk("ar_latch", latch_a, 0);
        chk("ar_cmd", cmd_a, 32'd0);
        chk("ar_count", cnt_a, 0);
        chk("ar_busy", busy_a, 0);
        chk("ar_full", full_a, 0);
        #4 reset = 1'b0;
        tick(1);
        wdata = 32'hBEEF_0001; wr_a = 1'b1; qa.push_back(wdata);
        tick(1); wr_a = 1'b0;
        tick(8);
        chk("ar_reissue_count", cnt_a, 1);
        chk("ar_reissue_cmd", cmd_a, 32'hBEEF_0001);

        // overflow on the long-setup instance
        for (int i = 0; i < 6; i++) begin
            wdata = 32'h100 + 32'(i); wr_b = 1'b1;
            if (i < 5) qb.push_back(wdata);
            tick(1);
        end
        wr_b = 1'b0;
        chk("ov_flag", ovf_b, 1);
        chk("ov_full", full_b, 1);
        tick(80);
        chk("ov_count", cnt_b, 5);
        chk("ov_idle", busy_b, 0);
        chk("ov_sticky", ovf_b, 1);
        flush = 1'b1;
        tick(1); flush = 1'b0;
        chk("ov_cleared", ovf_b, 0);

        // flush in the second setup cycle of the medium-setup instance
        wdata = 32'hCAFE_0001; wr_c = 1'b1;
        tick(1);
        wdata = 32'hCAFE_0002;
        tick(1); wr_c = 1'b0;
        chk("fu_cmd_w1", cmd_c, 32'hCAFE_0001);
        tick(1);
        flush = 1'b1;
        tick(1); flush = 1'b0;
        chk("fu_idle", busy_c, 0);
        chk("fu_cmd_hold", cmd_c, 32'hCAFE_0001);
        chk("fu_latch", latch_c, 0);
        tick(10);
        chk("fu_count", cnt_c, 0);
        chk("fu_still_idle", busy_c, 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
